// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the load-issue request, store-commit request, cache status and
//   registered cache-request slot signals of the data-cache port arbiter.
//   Modports:
//     master - request/cache side: drives ld_*, st_*, dc_miss, flush;
//              observes ld_ready, st_ready and the mc_* slot.
//     slave  - arbiter side: the mirror of master.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 4
);
    // Load issue path
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [ADDR_W-1:0] ld_pc;
    logic [IDX_W-1:0]  ld_index;
    logic              ld_ready;
    // Store commit path
    logic              st_valid;
    logic              st_urgent;
    logic [ADDR_W-1:0] st_addr;
    logic [ADDR_W-1:0] st_pc;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    // Cache status / pipeline control
    logic              dc_miss;
    logic              flush;
    // Registered cache-request slot
    logic              mc_valid;
    logic              mc_write;
    logic [ADDR_W-1:0] mc_addr;
    logic [ADDR_W-1:0] mc_pc;
    logic [DATA_W-1:0] mc_data;
    logic [IDX_W-1:0]  mc_index;
    logic              mc_squash;

    modport master (
        output ld_valid, ld_addr, ld_pc, ld_index,
        output st_valid, st_urgent, st_addr, st_pc, st_data,
        output dc_miss, flush,
        input  ld_ready, st_ready,
        input  mc_valid, mc_write, mc_addr, mc_pc, mc_data, mc_index, mc_squash
    );

    modport slave (
        input  ld_valid, ld_addr, ld_pc, ld_index,
        input  st_valid, st_urgent, st_addr, st_pc, st_data,
        input  dc_miss, flush,
        output ld_ready, st_ready,
        output mc_valid, mc_write, mc_addr, mc_pc, mc_data, mc_index, mc_squash
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single data-cache port between the load issue path and the
//   store-commit path. Grants at most one requester per cycle, captures the
//   winner into a registered cache-request slot (1-cycle latency), freezes
//   the slot while the cache reports a miss, marks a frozen load as squashed
//   on a misprediction flush, and optionally bounds store starvation.
//   Ports:
//     clk    - clock
//     rst_n  - synchronous active-low reset
//     bus    - mem_port_arbiter_if.slave (ld_*/st_* requests, dc_miss,
//              flush, ld_ready/st_ready grants, mc_* slot)
//   Configuration macro:
//     MEM_ARB_STARVE_GUARD_EN - when defined, a store denied STARVE_MAX
//     consecutive cycles is forced to win. Undefined: loads have priority
//     unless st_urgent, no load, or flush.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    if (STARVE_MAX < 2 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be in 2..15");
    end

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ISSUED,
        ST_MISS
    } state_e;

    state_e            state_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  index_q;
    logic              squash_q;

    logic grant_ld;
    logic grant_st;
    logic starve_force;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q;

    assign starve_force = (starve_q == 4'(STARVE_MAX));

    // Counts consecutive cycles a present store lost arbitration; frozen
    // during a miss because no arbitration happens then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (!bus.dc_miss) begin
            if (bus.st_valid && !grant_st) begin
                if (!starve_force) starve_q <= starve_q + 4'd1;
            end else begin
                starve_q <= '0;
            end
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    // Grants are gated by reset so a request pending during reset is not
    // reported as accepted.
    always_comb begin
        grant_st = 1'b0;
        grant_ld = 1'b0;
        if (rst_n && !bus.dc_miss) begin
            grant_st = bus.st_valid &&
                       (bus.st_urgent || starve_force || !bus.ld_valid || bus.flush);
            grant_ld = !grant_st && bus.ld_valid && !bus.flush;
        end
    end

    assign bus.ld_ready = grant_ld;
    assign bus.st_ready = grant_st;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            write_q  <= 1'b0;
            addr_q   <= '0;
            pc_q     <= '0;
            data_q   <= '0;
            index_q  <= '0;
            squash_q <= 1'b0;
        end else if (bus.dc_miss) begin
            // Freeze the slot; a flush can only mark a held load as dead.
            if (state_q != ST_EMPTY) begin
                state_q <= ST_MISS;
                if (bus.flush && !write_q) squash_q <= 1'b1;
            end
        end else if (grant_st) begin
            state_q  <= ST_ISSUED;
            write_q  <= 1'b1;
            addr_q   <= bus.st_addr;
            pc_q     <= bus.st_pc;
            data_q   <= bus.st_data;
            index_q  <= '0;
            squash_q <= 1'b0;
        end else if (grant_ld) begin
            state_q  <= ST_ISSUED;
            write_q  <= 1'b0;
            addr_q   <= bus.ld_addr;
            pc_q     <= bus.ld_pc;
            data_q   <= '0;
            index_q  <= bus.ld_index;
            squash_q <= 1'b0;
        end else begin
            // No grant: empty the slot, leave the payload fields as they were.
            state_q  <= ST_EMPTY;
            squash_q <= 1'b0;
        end
    end

    assign bus.mc_valid  = (state_q != ST_EMPTY);
    assign bus.mc_write  = write_q;
    assign bus.mc_addr   = addr_q;
    assign bus.mc_pc     = pc_q;
    assign bus.mc_data   = data_q;
    assign bus.mc_index  = index_q;
    assign bus.mc_squash = squash_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data-cache port between the load issue path and the store-commit path, ahead of the execute-to-memory pipeline register. Each cycle it grants at most one requester, captures the winning request into a registered cache-request slot, and freezes that slot while the cache reports a miss. It also squashes speculative loads on a branch misprediction, and bounds store starvation with an age counter.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, store data width
- IDX_W, 4, dispatch/active-list index width carried with loads
- STARVE_MAX, 4, consecutive denied store cycles before the store is forced to win (2..15)

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ld_valid  in  1  load request present
- ld_addr / ld_pc  in  ADDR_W each  load address / PC
- ld_index  in  IDX_W  load dispatch index
- ld_ready  out  1  load accepted this cycle (combinational)
- st_valid  in  1  committed store present
- st_urgent  in  1  store buffer full; store must win
- st_addr / st_pc  in  ADDR_W each  store address / PC
- st_data  in  DATA_W  store data
- st_ready  out  1  store accepted this cycle (combinational)
- dc_miss  in  1  cache miss on the current slot contents
- flush  in  1  misprediction: squash speculative loads
- mc_valid  out  1  slot holds a request
- mc_write  out  1  0 = READ (load), 1 = WRITE (store)
- mc_addr / mc_pc  out  ADDR_W each  slot address / PC
- mc_data  out  DATA_W  store data (0 for loads)
- mc_index  out  IDX_W  load index (0 for stores)
- mc_squash  out  1  slot load is dead; its result must be discarded

## Operation
- States: EMPTY (mc_valid=0), ISSUED (mc_valid=1, no miss), MISS (dc_miss=1 while mc_valid=1).
- Grant rule, evaluated only when dc_miss=0:
  - Store wins if st_valid && (st_urgent || starve_cnt==STARVE_MAX || !ld_valid || flush).
  - Otherwise the load wins if ld_valid && !flush.
- ld_ready = grant_ld; st_ready = grant_st. Both outputs are 0 whenever dc_miss=1.
- On a grant, the slot loads the request on the next edge. mc_data=0 for loads; mc_index=0 for stores. With no grant and dc_miss=0, the slot goes EMPTY: mc_valid=0, other fields hold.
- starve_cnt (4 bits):
  - Increments, saturating at STARVE_MAX, when st_valid && !grant_st && dc_miss=0.
  - Clears on grant_st or when st_valid=0.
  - Holds during dc_miss.
- Transitions:
  - EMPTY→ISSUED on grant.
  - ISSUED→MISS when dc_miss rises.
  - MISS→ISSUED or EMPTY on the first cycle with dc_miss=0, per the grant rule.
- Flush:
  - A load in the slot with dc_miss=0 is cleared: mc_valid=0 next cycle.
  - A load in the slot with dc_miss=1 is kept, mc_squash=1 next cycle, held until the slot is next loaded or emptied.
  - Stores are never squashed.
  - Flush in the same cycle as a load-only request: no grant.
- mc_squash clears whenever a new request is captured.
- Reset values: all mc_* = 0 (mc_write=0 = READ), starve_cnt=0, state EMPTY. Reset overrides dc_miss and flush. Reset mid-miss discards the slot.

## Timing
- Request-to-slot latency is 1 cycle: grant in cycle N, mc_* valid from N+1.
- Back-to-back grants are allowed every cycle with no bubble when dc_miss=0.
- Slot fields are frozen while dc_miss=1. The cache reads mc_addr as its held address.
- A request with valid=1 and ready=0 must hold its fields stable. The arbiter does not latch unaccepted requests.
- Simultaneous flush and dc_miss: freeze wins, squash marks the slot.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: starve_cnt and the forced-store rule are present.
- Undefined: starve_cnt is removed. Loads have strict priority except when st_urgent=1, !ld_valid, or flush=1.

## Test plan
- Reset: after rst_n=0 for 2 cycles, all mc_*=0, ld_ready=st_ready=0 with no requests.
- Load only, ld_addr=0x100, ld_index=3 in cycle N: ld_ready=1 in N; mc_valid=1, mc_write=0, mc_addr=0x100, mc_index=3 in N+1.
- Contention, ld_valid=st_valid=1 every cycle, STARVE_MAX=4:
  - Guard on: 4 load grants, then st_ready=1 on the 5th cycle, then the pattern repeats.
  - Guard off: zero store grants until st_urgent=1.
- Miss hold: store in slot, dc_miss=1 for 3 cycles with ld_valid=1: ld_ready=0 and slot unchanged for 3 cycles; load granted on the first cycle dc_miss=0.
- Flush:
  - Load in slot, dc_miss=0, flush=1: mc_valid=0 next cycle.
  - Load in slot, dc_miss=1, flush=1: mc_valid=1, mc_squash=1 until the miss clears.
  - Store in slot with flush: unaffected.
- Reset asserted during MISS with a load pending: slot empty next cycle, and the pending load is not granted in the reset cycle.
